// File: rtl/simd_divider.sv
// simd_divider: iterative unsigned SIMD divider using restoring shift-subtract.
// Divides packed 8-bit operands as one int8 lane, two int4 lanes or four int2
// lanes. All lanes are processed in parallel, and no borrows cross lane boundaries.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   in_valid / in_ready   operand handshake (accepted only in IDLE)
//   mode                  00 int8, 01 int4x2, 10 int2x4, 11 treated as 00
//   dividend, divisor     packed operand lanes
//   out_valid / out_ready result handshake (results held in DONE)
//   quotient, remainder   packed result lanes
//   div_by_zero           per-lane zero-divisor flag (bit i = lane i)
//
// Parameter STEPS_PER_CYCLE (1 or 2) sets the number of quotient bits resolved
// per lane per clock.
//
// Optional macro SIMD_DIVIDER_SIGNED_EN adds the signed_op input. When
// signed_op is 1, the lanes are two's complement: the divider works on the
// magnitudes and fixes up the signs in the final BUSY cycle.
module simd_divider #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] mode,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
`ifdef SIMD_DIVIDER_SIGNED_EN
  input  logic       signed_op,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic [3:0] div_by_zero
);

  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2) begin : g_bad_steps
    $error("simd_divider: STEPS_PER_CYCLE must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic [1:0] mode_p0;   // lane layout of the operation in flight
  logic [7:0] acc_p0;    // dividend bits shift out the top; quotient bits shift in at the bottom
  logic [7:0] rem_p0;    // per-lane partial remainders
  logic [7:0] dvs_p0;
  logic [3:0] cnt_p0;
  logic [3:0] dz_p0;
  logic [1:0] mode_n;
  logic [15:0] step1, step2;
  logic [7:0] nxt_acc, nxt_rem, fin_q, fin_r;

  // One restoring step on every lane. A zero divisor always passes the trial
  // subtraction, so that lane naturally yields an all-ones quotient and a
  // remainder equal to the dividend.
  function automatic logic [15:0] div_step(input logic [7:0] r, input logic [7:0] q,
                                           input logic [7:0] d, input logic [1:0] m);
    logic [7:0] nr, nq;
    logic [8:0] t8;
    logic [4:0] t4;
    logic [2:0] t2;
    nr = r;
    nq = q;
    case (m)
      2'b01: begin
        for (int l = 0; l < 2; l++) begin
          t4 = {r[l*4 +: 4], q[l*4+3]} - {1'b0, d[l*4 +: 4]};
          nq[l*4 +: 4] = {q[l*4 +: 3], ~t4[4]};
          nr[l*4 +: 4] = t4[4] ? {r[l*4 +: 3], q[l*4+3]} : t4[3:0];
        end
      end
      2'b10: begin
        for (int l = 0; l < 4; l++) begin
          t2 = {r[l*2 +: 2], q[l*2+1]} - {1'b0, d[l*2 +: 2]};
          nq[l*2 +: 2] = {q[l*2], ~t2[2]};
          nr[l*2 +: 2] = t2[2] ? {r[l*2], q[l*2+1]} : t2[1:0];
        end
      end
      default: begin
        t8 = {r, q[7]} - {1'b0, d};
        nq = {q[6:0], ~t8[8]};
        nr = t8[8] ? {r[6:0], q[7]} : t8[7:0];
      end
    endcase
    return {nr, nq};
  endfunction

  function automatic logic [3:0] zero_lanes(input logic [7:0] v, input logic [1:0] m);
    case (m)
      2'b01:   return {2'b00, v[7:4] == 4'd0, v[3:0] == 4'd0};
      2'b10:   return {v[7:6] == 2'd0, v[5:4] == 2'd0, v[3:2] == 2'd0, v[1:0] == 2'd0};
      default: return {3'b000, v == 8'd0};
    endcase
  endfunction

`ifdef SIMD_DIVIDER_SIGNED_EN
  logic [3:0] qneg_p0, rneg_p0;
  logic [3:0] sd_n, ss_n, dz_n;

  function automatic logic [3:0] lane_msbs(input logic [7:0] v, input logic [1:0] m);
    case (m)
      2'b01:   return {2'b00, v[7], v[3]};
      2'b10:   return {v[7], v[5], v[3], v[1]};
      default: return {3'b000, v[7]};
    endcase
  endfunction

  function automatic logic [7:0] cond_neg(input logic [7:0] v, input logic [3:0] f,
                                          input logic [1:0] m);
    logic [7:0] o;
    o = v;
    case (m)
      2'b01: for (int l = 0; l < 2; l++) if (f[l]) o[l*4 +: 4] = ~v[l*4 +: 4] + 4'd1;
      2'b10: for (int l = 0; l < 4; l++) if (f[l]) o[l*2 +: 2] = ~v[l*2 +: 2] + 2'd1;
      default: if (f[0]) o = ~v + 8'd1;
    endcase
    return o;
  endfunction

  function automatic logic [7:0] fill_ones(input logic [7:0] v, input logic [3:0] f,
                                           input logic [1:0] m);
    logic [7:0] o;
    o = v;
    case (m)
      2'b01: for (int l = 0; l < 2; l++) if (f[l]) o[l*4 +: 4] = 4'hF;
      2'b10: for (int l = 0; l < 4; l++) if (f[l]) o[l*2 +: 2] = 2'h3;
      default: if (f[0]) o = 8'hFF;
    endcase
    return o;
  endfunction

  always_comb begin
    sd_n = signed_op ? lane_msbs(dividend, mode_n) : 4'd0;
    ss_n = signed_op ? lane_msbs(divisor, mode_n) : 4'd0;
    dz_n = zero_lanes(divisor, mode_n);
  end
`endif

  assign mode_n    = (mode == 2'b11) ? 2'b00 : mode;
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_comb begin
    step1 = div_step(rem_p0, acc_p0, dvs_p0, mode_p0);
    step2 = div_step(step1[15:8], step1[7:0], dvs_p0, mode_p0);
    if (STEPS_PER_CYCLE == 2) begin
      nxt_rem = step2[15:8];
      nxt_acc = step2[7:0];
    end else begin
      nxt_rem = step1[15:8];
      nxt_acc = step1[7:0];
    end
`ifdef SIMD_DIVIDER_SIGNED_EN
    // Negating |remainder| restores the dividend on zero-divisor lanes; the
    // quotient on those lanes is forced back to all ones.
    fin_q = fill_ones(cond_neg(nxt_acc, qneg_p0, mode_p0), dz_p0, mode_p0);
    fin_r = cond_neg(nxt_rem, rneg_p0, mode_p0);
`else
    fin_q = nxt_acc;
    fin_r = nxt_rem;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_p0     <= 2'b00;
      acc_p0      <= 8'd0;
      rem_p0      <= 8'd0;
      dvs_p0      <= 8'd0;
      cnt_p0      <= 4'd0;
      dz_p0       <= 4'd0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      div_by_zero <= 4'd0;
`ifdef SIMD_DIVIDER_SIGNED_EN
      qneg_p0     <= 4'd0;
      rneg_p0     <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_p0 <= mode_n;
            rem_p0  <= 8'd0;
            dz_p0   <= zero_lanes(divisor, mode_n);
`ifdef SIMD_DIVIDER_SIGNED_EN
            acc_p0  <= cond_neg(dividend, sd_n, mode_n);
            dvs_p0  <= cond_neg(divisor, ss_n, mode_n);
            qneg_p0 <= (sd_n ^ ss_n) & ~dz_n;
            rneg_p0 <= sd_n;
`else
            acc_p0  <= dividend;
            dvs_p0  <= divisor;
`endif
            case (mode_n)
              2'b01:   cnt_p0 <= 4'(4 / STEPS_PER_CYCLE);
              2'b10:   cnt_p0 <= 4'(2 / STEPS_PER_CYCLE);
              default: cnt_p0 <= 4'(8 / STEPS_PER_CYCLE);
            endcase
            state <= BUSY;
          end
        end
        BUSY: begin
          acc_p0 <= nxt_acc;
          rem_p0 <= nxt_rem;
          cnt_p0 <= cnt_p0 - 4'd1;
          if (cnt_p0 == 4'd1) begin
            quotient    <= fin_q;
            remainder   <= fin_r;
            div_by_zero <= dz_p0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_divider.sv
module tb_simd_divider;
  localparam int STEPS = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [7:0] dividend;
  logic [7:0] divisor;
`ifdef SIMD_DIVIDER_SIGNED_EN
  logic       signed_op;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic [3:0] div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  simd_divider #(.STEPS_PER_CYCLE(STEPS)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .dividend(dividend),
    .divisor(divisor),
`ifdef SIMD_DIVIDER_SIGNED_EN
    .signed_op(signed_op),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic       sgn;
    logic [7:0] q;
    logic [7:0] r;
    logic [3:0] dz;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] m);
    case (m)
      2'b01:   return 4 / STEPS;
      2'b10:   return 2 / STEPS;
      default: return 8 / STEPS;
    endcase
  endfunction

  // Apply one operand set at a negedge; returns after the accept edge.
  task automatic start_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic s);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = m;
    dividend = a;
    divisor  = b;
`ifdef SIMD_DIVIDER_SIGNED_EN
    signed_op = s;
`else
    if (s) $display("note: signed vector in unsigned build");
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode     = 2'b00;
    dividend = 8'h00;
    divisor  = 8'h00;
  endtask

  // Bounded wait for out_valid; returns the number of edges since accept (0 = timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    start_op(v.mode, v.dvd, v.dvs, v.sgn);
    chk({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
    wait_done(lat);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_latency(v.mode)));
    chk({tag, ".quotient"}, 32'(quotient), 32'(v.q));
    chk({tag, ".remainder"}, 32'(remainder), 32'(v.r));
    chk({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(v.dz));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".handoff_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".handoff_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    vec_t hv;

    //            mode   dvd    dvs    sgn  q      r      dz
    vecs.push_back('{2'b00, 8'd200, 8'd7,  1'b0, 8'd28,  8'd4,  4'b0000});
    vecs.push_back('{2'b01, 8'hF3, 8'h42, 1'b0, 8'h31, 8'h31, 4'b0000});
    vecs.push_back('{2'b10, 8'hE7, 8'h4B, 1'b0, 8'hF1, 8'h24, 4'b0100});
    vecs.push_back('{2'b00, 8'h5A, 8'h00, 1'b0, 8'hFF, 8'h5A, 4'b0001});
    vecs.push_back('{2'b00, 8'h05, 8'h09, 1'b0, 8'h00, 8'h05, 4'b0000});
    vecs.push_back('{2'b11, 8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 4'b0000});
    vecs.push_back('{2'b00, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 4'b0000});
    vecs.push_back('{2'b01, 8'h70, 8'h30, 1'b0, 8'h2F, 8'h10, 4'b0001});
    vecs.push_back('{2'b10, 8'hFF, 8'hFF, 1'b0, 8'h55, 8'h00, 4'b0000});
    vecs.push_back('{2'b00, 8'hFF, 8'hFE, 1'b0, 8'h01, 8'h01, 4'b0000});
`ifdef SIMD_DIVIDER_SIGNED_EN
    vecs.push_back('{2'b00, 8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 4'b0000});
    vecs.push_back('{2'b00, 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 4'b0000});
    vecs.push_back('{2'b01, 8'h79, 8'hE2, 1'b1, 8'hDD, 8'h1F, 4'b0000});
    vecs.push_back('{2'b00, 8'h9C, 8'h00, 1'b1, 8'hFF, 8'h9C, 4'b0001});
    signed_op = 1'b0;
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 2'b00;
    dividend  = 8'h00;
    divisor   = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.quotient", 32'(quotient), 32'd0);
    chk("reset.remainder", 32'(remainder), 32'd0);
    chk("reset.div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.release_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: hold DONE for 5 cycles while in_valid toggles.
    start_op(2'b00, 8'd200, 8'd7, 1'b0);
    wait_done(lat);
    chk("bp.latency", 32'(lat), 32'(exp_latency(2'b00)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      mode     = 2'b10;
      dividend = 8'hAA;
      divisor  = 8'h11;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d.quotient", i), 32'(quotient), 32'd28);
      chk($sformatf("bp%0d.remainder", i), 32'(remainder), 32'd4);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.release_out_valid", 32'(out_valid), 32'd0);
    chk("bp.release_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp.no_accept_in_ready", 32'(in_ready), 32'd1);

    // Reset three cycles into an int8 operation.
    start_op(2'b00, 8'd77, 8'd5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.quotient", 32'(quotient), 32'd0);
    chk("midrst.remainder", 32'(remainder), 32'd0);
    chk("midrst.div_by_zero", 32'(div_by_zero), 32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.release_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("midrst.no_out_valid", 32'(seen), 32'd0);
    hv = '{2'b00, 8'd77, 8'd5, 1'b0, 8'd15, 8'd2, 4'b0000};
    run_vec("midrst.new_op", hv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
